// File: rtl/pc_unit.sv
// Fetch program counter with a one-entry pending-redirect buffer and a registered AdEL flag.
// Define PC_BOUND_CHECK_EN to also flag fetches outside [IMEM_LO, IMEM_HI].
module pc_unit #(
    parameter int unsigned WIDTH   = 32,
    parameter logic [31:0] INIT_PC = 32'h0000_3000,
    parameter logic [31:0] EXC_PC  = 32'h0000_4180,
    parameter logic [31:0] IMEM_LO = 32'h0000_3000,
    parameter logic [31:0] IMEM_HI = 32'h0000_6FFC
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic [WIDTH-1:0] next_pc,
    input  logic             req,
    input  logic [WIDTH-1:0] epc,
    input  logic             eret,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic             fetch_exc,
    output logic             pend_valid
);

    localparam logic [WIDTH-1:0] INIT_PC_W = WIDTH'(INIT_PC);
    localparam logic [WIDTH-1:0] EXC_PC_W  = WIDTH'(EXC_PC);

    // Elaboration-time sanity checks on the configuration
    if (WIDTH < 8) begin : g_bad_width
        $error("pc_unit: WIDTH must be at least 8");
    end
    if (IMEM_LO > IMEM_HI) begin : g_bad_range
        $error("pc_unit: IMEM_LO must not exceed IMEM_HI");
    end

`ifdef PC_BOUND_CHECK_EN
    localparam logic [WIDTH-1:0] IMEM_LO_W = WIDTH'(IMEM_LO);
    localparam logic [WIDTH-1:0] IMEM_HI_W = WIDTH'(IMEM_HI);

    function automatic logic exc_of(input logic [WIDTH-1:0] addr);
        return (addr[1:0] != 2'b00) || (addr < IMEM_LO_W) || (addr > IMEM_HI_W);
    endfunction
`else
    function automatic logic exc_of(input logic [WIDTH-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction
`endif

    logic [WIDTH-1:0] pend_addr;
    logic [WIDTH-1:0] pc_d;
    logic [WIDTH-1:0] pend_addr_d;
    logic             pend_valid_d;

    // Redirect priority: exception, stall (buffer eret), live eret, buffered eret, sequential
    always_comb begin
        pc_d         = next_pc;
        pend_addr_d  = pend_addr;
        pend_valid_d = pend_valid;
        if (req) begin
            pc_d         = EXC_PC_W;
            pend_valid_d = 1'b0;
        end else if (stall) begin
            pc_d = pc;
            if (eret) begin
                pend_addr_d  = epc;
                pend_valid_d = 1'b1;
            end
        end else if (eret) begin
            pc_d         = epc;
            pend_valid_d = 1'b0;
        end else if (pend_valid) begin
            pc_d         = pend_addr;
            pend_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc         <= INIT_PC_W;
            fetch_exc  <= exc_of(INIT_PC_W);
            pend_addr  <= '0;
            pend_valid <= 1'b0;
        end else begin
            pc         <= pc_d;
            fetch_exc  <= exc_of(pc_d);
            pend_addr  <= pend_addr_d;
            pend_valid <= pend_valid_d;
        end
    end

    assign pc_plus4 = pc + WIDTH'(4);

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit: redirects, stall buffering, AdEL flag, wrap.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [31:0] next_pc;
    logic        req;
    logic [31:0] epc;
    logic        eret;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_exc;
    logic        pend_valid;

    int n_cmp = 0;
    int n_err = 0;

`ifdef PC_BOUND_CHECK_EN
    localparam logic OOB_EXC = 1'b1;
`else
    localparam logic OOB_EXC = 1'b0;
`endif

    pc_unit dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .next_pc   (next_pc),
        .req       (req),
        .epc       (epc),
        .eret      (eret),
        .pc        (pc),
        .pc_plus4  (pc_plus4),
        .fetch_exc (fetch_exc),
        .pend_valid(pend_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset   = 1'b0;
        stall   = 1'b0;
        next_pc = 32'h0;
        req     = 1'b0;
        epc     = 32'h0;
        eret    = 1'b0;

        // Async reset asserted mid-cycle
        #7 reset = 1'b1;
        #1;
        check("rst_pc", pc, 32'h0000_3000);
        check("rst_pv", 32'(pend_valid), 32'h0);
        check("rst_fe", 32'(fetch_exc), 32'h0);
        check("rst_p4", pc_plus4, 32'h0000_3004);
        tick();
        reset = 1'b0;

        // Free run
        next_pc = 32'h3004; tick();
        check("run1_pc", pc, 32'h3004);
        check("run1_p4", pc_plus4, 32'h3008);
        check("run1_fe", 32'(fetch_exc), 32'h0);
        next_pc = 32'h3008; tick();
        check("run2_pc", pc, 32'h3008);
        next_pc = 32'h300C; tick();
        check("run3_pc", pc, 32'h300C);
        check("run3_fe", 32'(fetch_exc), 32'h0);

        // Stall with single-cycle eret pulse
        stall = 1'b1; eret = 1'b1; epc = 32'h3040; next_pc = 32'h3010; tick();
        check("stl1_pc", pc, 32'h300C);
        check("stl1_pv", 32'(pend_valid), 32'h1);
        eret = 1'b0; tick();
        check("stl2_pc", pc, 32'h300C);
        check("stl2_pv", 32'(pend_valid), 32'h1);
        tick();
        check("stl3_pc", pc, 32'h300C);
        stall = 1'b0; tick();
        check("unstl_pc", pc, 32'h3040);
        check("unstl_pv", 32'(pend_valid), 32'h0);

        // Exception beats stall and eret
        stall = 1'b1; eret = 1'b1; epc = 32'h3100; req = 1'b1; tick();
        check("exc_pc", pc, 32'h4180);
        check("exc_pv", 32'(pend_valid), 32'h0);
        check("exc_fe", 32'(fetch_exc), 32'h0);
        stall = 1'b0; eret = 1'b0; req = 1'b0; next_pc = 32'h4184; tick();
        check("exc_nxt", pc, 32'h4184);

        // Last-wins buffer, then live eret overrides it
        stall = 1'b1; eret = 1'b1; epc = 32'h3200; tick();
        epc = 32'h3300; tick();
        check("lw_addr", dut.pend_addr, 32'h3300);
        check("lw_pv", 32'(pend_valid), 32'h1);
        check("lw_hold", pc, 32'h4184);
        stall = 1'b0; epc = 32'h3400; tick();
        check("live_pc", pc, 32'h3400);
        check("live_pv", 32'(pend_valid), 32'h0);
        eret = 1'b0; next_pc = 32'h3404; tick();
        check("live_nxt", pc, 32'h3404);

        // Last-wins buffer applied on unstall without live eret
        stall = 1'b1; eret = 1'b1; epc = 32'h3200; tick();
        epc = 32'h3300; tick();
        stall = 1'b0; eret = 1'b0; next_pc = 32'h3500; tick();
        check("buf_pc", pc, 32'h3300);
        check("buf_pv", 32'(pend_valid), 32'h0);
        next_pc = 32'h3304; tick();
        check("buf_nxt", pc, 32'h3304);

        // Misaligned fetch
        next_pc = 32'h3006; tick();
        check("mis_pc", pc, 32'h3006);
        check("mis_fe", 32'(fetch_exc), 32'h1);
        next_pc = 32'h3008; tick();
        check("al_fe", 32'(fetch_exc), 32'h0);

        // Bound check (only effective with the optional feature)
        next_pc = 32'h7000; tick();
        check("oob_fe", 32'(fetch_exc), 32'(OOB_EXC));
        next_pc = 32'h6FFC; tick();
        check("hi_fe", 32'(fetch_exc), 32'h0);

        // pc_plus4 wrap at all-ones
        next_pc = 32'hFFFF_FFFF; tick();
        check("wrap_pc", pc, 32'hFFFF_FFFF);
        check("wrap_p4", pc_plus4, 32'h0000_0003);
        check("wrap_fe", 32'(fetch_exc), 32'h1);

        // Reset mid-stall discards a pending redirect
        stall = 1'b1; eret = 1'b1; epc = 32'h3600; tick();
        check("prs_pv", 32'(pend_valid), 32'h1);
        eret = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("mrst_pc", pc, 32'h3000);
        check("mrst_pv", 32'(pend_valid), 32'h0);
        check("mrst_fe", 32'(fetch_exc), 32'h0);
        tick();
        reset = 1'b0; stall = 1'b0; next_pc = 32'h3004; tick();
        check("mrst_nxt", pc, 32'h3004);
        check("mrst_pv2", 32'(pend_valid), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
